// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: aliased word RAM below MMIO_BASE plus a small peripheral block
// (cycle counter, compare flag, GPIO, console TX FIFO) in the top region.
module dmem_mmio_responder #(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] readdata_o,
    output logic [31:0] gpio_out_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [3:0] OffCycle     = 4'h0;
    localparam logic [3:0] OffCmp       = 4'h1;
    localparam logic [3:0] OffStatus    = 4'h2;
    localparam logic [3:0] OffStatusClr = 4'h3;
    localparam logic [3:0] OffGpio      = 4'h4;
    localparam logic [3:0] OffConTx     = 4'h5;

    localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);

    logic [31:0]   ram_q [MEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   cmp_q, cmp_d;
    logic [31:0]   gpio_q, gpio_d;
    logic          hit_q, hit_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          is_mmio;
    logic [3:0]    off;
    logic [AW-1:0] ram_idx;
    logic          wr_mmio;
    logic          wr_ram;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic [3:0]    count4;

    assign is_mmio    = (addr_i >= MMIO_BASE);
    assign off        = addr_i[5:2];
    assign ram_idx    = addr_i[AW+1:2];
    assign wr_mmio    = memwrite_i & is_mmio;
    assign wr_ram     = memwrite_i & ~is_mmio;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);
    assign push_req   = wr_mmio & (off == OffConTx);
    // A push into a full FIFO is dropped even when a pop frees a slot at the same edge.
    assign push       = push_req & ~fifo_full;
    assign pop        = ~fifo_empty & con_ready_i;
    assign count4     = 4'(count_q);

    assign gpio_out_o  = gpio_q;
    assign con_valid_o = ~fifo_empty;
    assign con_data_o  = fifo_empty ? 8'h00 : fifo_q[head_q];

    always_comb begin
        readdata_o = '0;
        if (!is_mmio) begin
            readdata_o = ram_q[ram_idx];
        end else begin
            case (off)
                OffCycle:  readdata_o = cycle_q;
                OffCmp:    readdata_o = cmp_q;
                OffStatus: readdata_o = {24'h0, count4, fifo_full, fifo_empty, ovf_q, hit_q};
                OffGpio:   readdata_o = gpio_q;
                default:   readdata_o = '0;
            endcase
        end
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        cmp_d   = cmp_q;
        gpio_d  = gpio_q;
        hit_d   = hit_q;
        ovf_d   = ovf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (wr_mmio && off == OffCycle) cycle_d = writedata_i;
        if (wr_mmio && off == OffCmp)   cmp_d   = writedata_i;
        if (wr_mmio && off == OffGpio)  gpio_d  = writedata_i;

        // Clears are applied first so that a same-cycle set takes priority.
        if (wr_mmio && off == OffStatusClr && writedata_i[0]) hit_d = 1'b0;
        if (wr_mmio && off == OffStatusClr && writedata_i[1]) ovf_d = 1'b0;
        if (cycle_q == cmp_q)         hit_d = 1'b1;
        if (push_req && fifo_full)    ovf_d = 1'b1;

        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ram) ram_q[ram_idx] <= writedata_i;
        if (push)   fifo_q[tail_q] <= writedata_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            gpio_q  <= '0;
            hit_q   <= 1'b0;
            ovf_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            gpio_q  <= gpio_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
